// File: rtl/count_sequence_checker_pkg.sv
// Shared types and default sizes for the count sequence checker.
package count_sequence_checker_pkg;

    localparam int WIDTH_DEFAULT = 4;
    localparam int ERR_W_DEFAULT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_e;

endpackage

// File: rtl/count_sequence_checker_sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment leaves a count of one.
module sat_counter #(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [ERR_W-1:0] count
);

    logic [ERR_W-1:0] cnt_q;
    logic [ERR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = ERR_W'(inc);
        end else if (inc && (cnt_q != {ERR_W{1'b1}})) begin
            cnt_d = cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Watches an external counter and flags any step that is not +1 (enabled) or hold (disabled).
module count_sequence_checker
    import count_sequence_checker_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int ERR_W = ERR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] count,
    input  logic             clear,
    output logic [WIDTH-1:0] expected,
    output logic             mismatch,
    output logic             wrap,
    output logic             fault,
    output logic [ERR_W-1:0] err_count,
    output logic             in_sync
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_count_q, prev_count_d;
    logic             prev_en_q, prev_en_d;
    logic             mismatch_q, mismatch_d;
    logic             wrap_q, wrap_d;
    logic             fault_q, fault_d;
    logic             violation;

    always_comb begin
        expected = prev_en_q ? prev_count_q + WIDTH'(1) : prev_count_q;
    end

    always_comb begin
        state_d      = state_q;
        prev_count_d = count;
        prev_en_d    = enable;
        violation    = 1'b0;
        wrap_d       = 1'b0;
        fault_d      = fault_q;

        case (state_q)
            IDLE: begin
                state_d = TRACK;
            end
            TRACK: begin
                violation = (count != expected);
                wrap_d    = prev_en_q && (prev_count_q == {WIDTH{1'b1}}) &&
                            (count == '0);
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A violation wins over clear so the cycle's event is never lost.
        if (violation) begin
            fault_d = 1'b1;
        end else if (clear) begin
            fault_d = 1'b0;
        end
        mismatch_d = violation;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prev_count_q <= '0;
            prev_en_q    <= 1'b0;
            mismatch_q   <= 1'b0;
            wrap_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_count_q <= prev_count_d;
            prev_en_q    <= prev_en_d;
            mismatch_q   <= mismatch_d;
            wrap_q       <= wrap_d;
            fault_q      <= fault_d;
        end
    end

    sat_counter #(
        .ERR_W(ERR_W)
    ) u_err_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (violation),
        .clr  (clear),
        .count(err_count)
    );

    assign mismatch = mismatch_q;
    assign wrap     = wrap_q;
    assign fault    = fault_q;
    assign in_sync  = (state_q == TRACK);

endmodule

// File: doc/count_sequence_checker.md
COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

Interface
REQ-001 Parameter WIDTH, default 4: width of the observed count bus.
REQ-002 Parameter ERR_W, default 8: width of the saturating error counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  increment enable, as seen by the observed counter.
REQ-006 count  input  WIDTH  observed counter value; registered by the counter on the same clk.
REQ-007 clear  input  1  synchronous clear of fault and err_count.
REQ-008 expected  output  WIDTH  predicted count for the current cycle.
REQ-009 mismatch  output  1  one-cycle pulse flagging a sequence violation.
REQ-010 wrap  output  1  one-cycle pulse on a legal (2^WIDTH-1) -> 0 transition.
REQ-011 fault  output  1  sticky error flag.
REQ-012 err_count  output  ERR_W  saturating count of mismatches.
REQ-013 in_sync  output  1  high while in TRACK state.

Function
REQ-014 The block SHALL register count and enable every cycle as prev_count and prev_en.
REQ-015 Prediction: expected SHALL equal prev_count+1 mod 2^WIDTH when prev_en=1, else prev_count; it is combinational from the registers.
REQ-016 The FSM SHALL have states IDLE and TRACK; reset enters IDLE.
REQ-017 IDLE -> TRACK after the first clock edge following reset release; no comparison occurs in IDLE.
REQ-018 In TRACK, the block SHALL compare count against expected each cycle; inequality is a violation.
REQ-019 mismatch SHALL assert exactly one cycle after the violating count is sampled (registered, latency 1).
REQ-020 On violation: err_count increments and saturates at 2^ERR_W-1; fault sets and stays set.
REQ-021 Resync: the violating count SHALL become prev_count, so a single jump produces exactly one mismatch.
REQ-022 wrap SHALL pulse, with latency 1, when prev_count=2^WIDTH-1, prev_en=1 and count=0; it SHALL NOT pulse on a mismatch.
REQ-023 enable=0 with count changing SHALL be a violation.
REQ-024 clear=1 SHALL zero err_count and deassert fault on the next edge.
REQ-025 If clear and a violation occur in the same cycle, the result SHALL be err_count=1 and fault=1.
REQ-026 The FSM SHALL remain in TRACK after violations; only reset returns it to IDLE.

Reset
REQ-027 While rst_n=0: state=IDLE, prev_count=0, prev_en=0, mismatch=0, wrap=0, fault=0, err_count=0, in_sync=0.
REQ-028 Reset asserted mid-operation SHALL clear all state immediately, without waiting for clk.
REQ-029 The first cycle after reset release SHALL NOT flag a mismatch, whatever the value of count.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE, TRACK) and the default WIDTH/ERR_W constants.
REQ-031 One sub-module, sat_counter (parameter ERR_W; inputs inc and clr), SHALL implement err_count.
REQ-032 The expected-value logic SHALL be purely combinational; no other sub-modules SHALL be used.

Verification
REQ-033 enable=1 with count 0..15, then 0 -> no mismatch; wrap pulses once, one cycle after count=0 is sampled.
REQ-034 enable=1 with count 8, 9, 10, 0 -> mismatch pulses once one cycle after 0 is sampled (expected=11); err_count=1; fault=1.
REQ-035 enable=0 with count held at 5, then 6 -> mismatch on the 6; err_count increments.
REQ-036 300 forced violations -> err_count saturates at 255; clear -> err_count=0, fault=0.
REQ-037 clear asserted in the same cycle as a violation -> err_count=1, fault=1.
REQ-038 rst_n pulsed low mid-count at value 7 -> all outputs 0 asynchronously; first sample after release (any value) -> no mismatch; in_sync rises the next cycle.
